range_finder_win: RTL

// - Parametrised successor to the single-shot range finder. Tracks the min and max of data_in over a go..finish window and reports range = max - min.
// - Adds signed mode, sample counter, auto-finish at a sample limit, a result-valid strobe and protocol-error detection.
// - Sits between the chip's io_in sample bus and io_out. The chip top ties WIDTH to 12.
//

---
 rtl/range_finder_win.sv | 121 ++++++++++++
 1 files changed

// File: rtl/range_finder_win.sv
// Windowed min/max/range tracker with signed mode, sample limit and protocol-error flag.
// Optional sticky error behaviour: define RANGE_FINDER_STICKY_ERR_EN.
module range_finder_win #(
    parameter int WIDTH       = 12,
    parameter int SIGNED      = 0,
    parameter int MAX_SAMPLES = 255,
    localparam int CNT_W      = $clog2(MAX_SAMPLES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             go,
    input  logic             finish,
    output logic [WIDTH-1:0] range,
    output logic             range_valid,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             error
);

    // Handshake: go/finish are level-sampled every rising edge with no backpressure;
    // range_valid is a one-cycle strobe that qualifies a new range, which then holds.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] range_d, min_d, max_d;
    logic [WIDTH-1:0] lo, hi;
    logic [WIDTH:0]   ext_hi, ext_lo, diff;
    logic [WIDTH-1:0] diff_sat;
    logic [CNT_W-1:0] cnt_d, cnt_inc;
    logic             rv_d, err_now, err_d;

    function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) < $signed(b);
        else             return a < b;
    endfunction

    always_comb begin
        lo      = less(data_in, min_out) ? data_in : min_out;
        hi      = less(max_out, data_in) ? data_in : max_out;
        cnt_inc = count + CNT_W'(1);
        ext_hi  = (SIGNED != 0) ? {hi[WIDTH-1], hi} : {1'b0, hi};
        ext_lo  = (SIGNED != 0) ? {lo[WIDTH-1], lo} : {1'b0, lo};
        // hi >= lo, so the WIDTH+1 bit difference is non-negative; its top bit means overflow.
        diff     = ext_hi - ext_lo;
        diff_sat = diff[WIDTH] ? {WIDTH{1'b1}} : diff[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        range_d = range;
        rv_d    = 1'b0;
        min_d   = min_out;
        max_d   = max_out;
        cnt_d   = count;
        err_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    min_d = data_in;
                    max_d = data_in;
                    cnt_d = CNT_W'(1);
                    if (finish || (MAX_SAMPLES == 1)) begin
                        range_d = '0;
                        rv_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (finish) begin
                    err_now = 1'b1;
                end
            end
            RUN: begin
                min_d   = lo;
                max_d   = hi;
                cnt_d   = cnt_inc;
                err_now = go;
                if (finish || (cnt_inc == CNT_W'(MAX_SAMPLES))) begin
                    range_d = diff_sat;
                    rv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef RANGE_FINDER_STICKY_ERR_EN
        // An accepted go clears the latched flag unless that same cycle raises a new error.
        err_d = ((state_q == IDLE) && go) ? err_now : (error | err_now);
`else
        err_d = err_now;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            range       <= '0;
            range_valid <= 1'b0;
            min_out     <= '0;
            max_out     <= '0;
            count       <= '0;
            busy        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            range       <= range_d;
            range_valid <= rv_d;
            min_out     <= min_d;
            max_out     <= max_d;
            count       <= cnt_d;
            busy        <= (state_d == RUN);
            error       <= err_d;
        end
    end

endmodule
